// File: rtl/rc_dsp_pkg.sv
// Shared types and constants for the block serializer output stage.
// Sample width, unroll factor, block container type and read-index helpers.
package rc_dsp_pkg;

    localparam int DWIDTH = 15;
    localparam int UNR    = 4;
    localparam int IDX_W  = (UNR > 1) ? $clog2(UNR) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UNR - 1);

    typedef logic [DWIDTH-1:0] sample_t;
    typedef sample_t           block_t [UNR];

    // Number of buffered blocks in the ping-pong store
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [IDX_W-1:0] idx_advance(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/blk_pingpong2.sv
// Two-entry block store with write/read slot pointers and occupancy tracking.
// rd_blk presents the read slot's contents as they will be after the current edge.
module blk_pingpong2
    import rc_dsp_pkg::*;
(
    input  logic   CLK,
    input  logic   RST_N,
    input  logic   push,
    input  block_t push_blk,
    input  logic   pop_blk,
    output logic   full,
    output logic   empty,
    output logic   full_next,
    output logic   empty_next,
    output block_t rd_blk
);

    occ_e    occ_reg;
    occ_e    occ_next;
    logic    wr_reg;
    logic    rd_reg;
    logic    rd_sel;
    sample_t slot_reg [2][UNR];

    assign full       = (occ_reg == OCC_FULL);
    assign empty      = (occ_reg == OCC_EMPTY);
    assign full_next  = (occ_next == OCC_FULL);
    assign empty_next = (occ_next == OCC_EMPTY);

    // Callers never push while full or pop a block while empty.
    always_comb begin
        occ_next = occ_reg;
        unique case (occ_reg)
            OCC_EMPTY: begin
                if (push)
                    occ_next = OCC_ONE;
            end
            OCC_ONE: begin
                if (push && !pop_blk)
                    occ_next = OCC_FULL;
                else if (!push && pop_blk)
                    occ_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop_blk)
                    occ_next = OCC_ONE;
            end
            default: occ_next = OCC_EMPTY;
        endcase
    end

    // Look-ahead view: a block written this cycle into the slot that becomes
    // the read slot is forwarded so the next sample register sees it at once.
    assign rd_sel = rd_reg ^ pop_blk;

    always_comb begin
        for (int j = 0; j < UNR; j++) begin
            rd_blk[j] = slot_reg[rd_sel][j];
            if (push && (wr_reg == rd_sel))
                rd_blk[j] = push_blk[j];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occ_reg <= OCC_EMPTY;
            wr_reg  <= 1'b0;
            rd_reg  <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                for (int j = 0; j < UNR; j++) begin
                    slot_reg[s][j] <= '0;
                end
            end
        end else begin
            occ_reg <= occ_next;
            if (push) begin
                for (int j = 0; j < UNR; j++) begin
                    slot_reg[wr_reg][j] <= push_blk[j];
                end
                wr_reg <= ~wr_reg;
            end
            if (pop_blk)
                rd_reg <= ~rd_reg;
        end
    end

endmodule

// File: rtl/blk_serializer.sv
// Block-to-serial output stage: UNR samples per accepted block, one per cycle out.
// Optional underrun counter enabled by defining SER_UNDERRUN_CNT_EN.
module blk_serializer
    import rc_dsp_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] din [UNR],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] dout
`ifdef SER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    logic             push;
    logic             pop;
    logic             pop_blk;
    logic             full;
    logic             empty;
    logic             full_next;
    logic             empty_next;
    block_t           rd_blk;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic             in_ready_reg;
    sample_t          dout_reg;
    sample_t          dout_next;

    assign out_valid = ~empty;
    assign in_ready  = in_ready_reg;
    assign dout      = dout_reg;

    assign push    = in_valid & in_ready_reg & ~full;
    assign pop     = out_valid & out_ready;
    assign pop_blk = pop & (idx_reg == IDX_LAST);

    blk_pingpong2 u_pingpong (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (push),
        .push_blk   (din),
        .pop_blk    (pop_blk),
        .full       (full),
        .empty      (empty),
        .full_next  (full_next),
        .empty_next (empty_next),
        .rd_blk     (rd_blk)
    );

    // dout is loaded one edge ahead so it is a plain register at the port;
    // when the store drains it keeps the last emitted sample.
    always_comb begin
        idx_next = idx_reg;
        if (pop)
            idx_next = idx_advance(idx_reg);
        dout_next = dout_reg;
        if (!empty_next)
            dout_next = rd_blk[idx_next];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            dout_reg     <= '0;
        end else begin
            idx_reg      <= idx_next;
            in_ready_reg <= ~full_next;
            dout_reg     <= dout_next;
        end
    end

`ifdef SER_UNDERRUN_CNT_EN
    logic        started_reg;
    logic [15:0] underrun_cnt_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            started_reg      <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            if (push)
                started_reg <= 1'b1;
            if (started_reg && out_ready && !out_valid && (underrun_cnt_reg != 16'hFFFF))
                underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_reg;
`endif

endmodule

// File: tb/tb_blk_serializer.sv
// Self-checking bench for blk_serializer: vector table, corner sequences and
// randomized traffic against a sample-queue reference model.
module tb_blk_serializer;
    import rc_dsp_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] din [UNR];
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] dout;
`ifdef SER_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    blk_serializer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
`ifdef SER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: flat queue of pending samples; occupancy is the number
    // of (whole) blocks still holding unsent samples.
    sample_t     q[$];
    sample_t     last_mdl;
    bit          ready_en;
    int unsigned cnt_mdl;
    bit          started_mdl;

    logic    ov_obs;
    logic    ir_obs;
    sample_t dout_obs;
    sample_t rx[$];

    typedef struct {
        logic    iv;
        block_t  blk;
        logic    ordy;
        logic    exp_ov;
        logic    exp_ir;
        sample_t exp_dout;
    } vec_t;

    localparam int NT = 20;
    vec_t tbl [NT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int mdl_occ();
        return (q.size() + UNR - 1) / UNR;
    endfunction

    function automatic block_t mk_blk(input int base);
        block_t b;
        for (int j = 0; j < UNR; j++) b[j] = sample_t'(base + j);
        return b;
    endfunction

    function automatic block_t rand_blk();
        block_t b;
        for (int j = 0; j < UNR; j++) b[j] = sample_t'($urandom);
        return b;
    endfunction

    function automatic vec_t mkrow(input logic iv, input int base, input logic ordy,
                                   input logic ov, input logic ir, input int d);
        vec_t v;
        v.iv       = iv;
        v.blk      = mk_blk(base);
        v.ordy     = ordy;
        v.exp_ov   = ov;
        v.exp_ir   = ir;
        v.exp_dout = sample_t'(d);
        return v;
    endfunction

    // One clock: drive, compare against the model, advance the model, step.
    task automatic cycle(input logic iv, input block_t b, input logic ordy);
        bit      m_ov;
        bit      m_ir;
        bit      acc;
        bit      pp;
        sample_t m_dout;
        in_valid  = iv;
        din       = b;
        out_ready = ordy;
        #1;
        m_ov   = (q.size() > 0);
        m_ir   = ready_en && (mdl_occ() < 2);
        m_dout = m_ov ? q[0] : last_mdl;
        ov_obs   = out_valid;
        ir_obs   = in_ready;
        dout_obs = dout;
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, m_ir);
        chk("dout", dout, m_dout);
`ifdef SER_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, cnt_mdl);
`endif
        if (RST_N) begin
            acc = iv && m_ir;
            pp  = m_ov && ordy;
            if (started_mdl && ordy && !m_ov && cnt_mdl < 32'hFFFF) cnt_mdl++;
            if (acc) started_mdl = 1'b1;
            if (pp) begin
                last_mdl = q.pop_front();
                rx.push_back(dout_obs);
                $display("t=%0t pop   dout=%0h", $time, dout_obs);
            end
            if (acc) begin
                for (int j = 0; j < UNR; j++) q.push_back(b[j]);
                $display("t=%0t accept din0=%0h din%0d=%0h", $time, b[0], UNR - 1, b[UNR-1]);
            end
        end
        @(posedge CLK);
        #1;
        if (RST_N) ready_en = 1'b1;
    endtask

    task automatic mdl_clear();
        q.delete();
        last_mdl    = '0;
        ready_en    = 1'b0;
        cnt_mdl     = 0;
        started_mdl = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        mdl_clear();
        repeat (4) cycle(1'($urandom), rand_blk(), 1'($urandom));
        RST_N = 1'b1;
        cycle(1'b0, rand_blk(), 1'b0);
        chk("rdy_low_at_release", ir_obs, 1'b0);
    endtask

    initial begin
        bit     c_pending;
        block_t zb;
        zb        = mk_blk(0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = zb;
        mdl_clear();
        #1;

        // Reset state, then in_ready one edge after release
        do_reset();
        cycle(1'b0, zb, 1'b0);
        chk("rdy_after_release", ir_obs, 1'b1);

        // Single block then back-to-back blocks
        tbl[0]  = mkrow(1, 1, 1, 0, 1, 0);
        tbl[1]  = mkrow(0, 0, 1, 1, 1, 1);
        tbl[2]  = mkrow(0, 0, 1, 1, 1, 2);
        tbl[3]  = mkrow(0, 0, 1, 1, 1, 3);
        tbl[4]  = mkrow(0, 0, 1, 1, 1, 4);
        tbl[5]  = mkrow(0, 0, 1, 0, 1, 4);
        tbl[6]  = mkrow(1, 1, 1, 0, 1, 4);
        tbl[7]  = mkrow(1, 5, 1, 1, 1, 1);
        tbl[8]  = mkrow(1, 9, 1, 1, 0, 2);
        tbl[9]  = mkrow(1, 9, 1, 1, 0, 3);
        tbl[10] = mkrow(1, 9, 1, 1, 0, 4);
        tbl[11] = mkrow(1, 9, 1, 1, 1, 5);
        tbl[12] = mkrow(0, 0, 1, 1, 0, 6);
        tbl[13] = mkrow(0, 0, 1, 1, 0, 7);
        tbl[14] = mkrow(0, 0, 1, 1, 0, 8);
        tbl[15] = mkrow(0, 0, 1, 1, 1, 9);
        tbl[16] = mkrow(0, 0, 1, 1, 1, 10);
        tbl[17] = mkrow(0, 0, 1, 1, 1, 11);
        tbl[18] = mkrow(0, 0, 1, 1, 1, 12);
        tbl[19] = mkrow(0, 0, 1, 0, 1, 12);
        for (int i = 0; i < NT; i++) begin
            cycle(tbl[i].iv, tbl[i].blk, tbl[i].ordy);
            chk($sformatf("tbl%0d_ov", i), ov_obs, tbl[i].exp_ov);
            chk($sformatf("tbl%0d_ir", i), ir_obs, tbl[i].exp_ir);
            chk($sformatf("tbl%0d_dout", i), dout_obs, tbl[i].exp_dout);
        end

        // Backpressure: two blocks stored, third pending while out_ready=0
        rx.delete();
        cycle(1'b1, mk_blk(1), 1'b0);
        cycle(1'b1, mk_blk(5), 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, mk_blk(9), 1'b0);
            chk("stall_ir", ir_obs, 1'b0);
            chk("stall_dout", dout_obs, 1);
        end
        c_pending = 1'b1;
        for (int k = 0; k < 40 && rx.size() < 12; k++) begin
            cycle(c_pending, mk_blk(9), 1'b1);
            if (c_pending && ir_obs) c_pending = 1'b0;
        end
        chk("stall_rx_count", rx.size(), 12);
        for (int i = 0; i < 12 && i < rx.size(); i++) chk("stall_rx_order", rx[i], i + 1);

        // Reset in the middle of a block
        do_reset();
        cycle(1'b1, mk_blk(1), 1'b1);
        cycle(1'b0, zb, 1'b1);
        cycle(1'b0, zb, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("midrst_ov", out_valid, 1'b0);
        chk("midrst_dout", dout, 0);
        chk("midrst_ir", in_ready, 1'b0);
        mdl_clear();
        cycle(1'b0, zb, 1'b1);
        RST_N = 1'b1;
        cycle(1'b0, zb, 1'b1);
        rx.delete();
        cycle(1'b1, mk_blk(7), 1'b1);
        cycle(1'b0, zb, 1'b1);
        chk("midrst_first_ov", ov_obs, 1'b1);
        chk("midrst_first", dout_obs, 7);
        repeat (4) cycle(1'b0, zb, 1'b1);
        chk("midrst_rx_count", rx.size(), 4);
        for (int i = 0; i < 4 && i < rx.size(); i++) chk("midrst_rx", rx[i], 7 + i);

        // Randomized traffic with occasional long stalls
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if (n % 100 < 15) cycle(1'($urandom), rand_blk(), 1'b0);
            else cycle(($urandom % 4) != 0, rand_blk(), ($urandom % 3) != 0);
        end

`ifdef SER_UNDERRUN_CNT_EN
        do_reset();
        repeat (3) cycle(1'b0, zb, 1'b1);
        chk("unr_before_first", underrun_cnt, 0);
        cycle(1'b1, mk_blk(1), 1'b1);
        repeat (4) cycle(1'b0, zb, 1'b1);
        repeat (5) cycle(1'b0, zb, 1'b1);
        chk("unr_five", underrun_cnt, 5);
        force dut.underrun_cnt_reg = 16'hFFFE;
        #2;
        release dut.underrun_cnt_reg;
        cnt_mdl = 32'hFFFE;
        repeat (4) cycle(1'b0, zb, 1'b1);
        chk("unr_sat", underrun_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
